// File: rtl/dbg_mbox_pkg.sv
// dbg_mbox_pkg
// Shared constants for the Wishbone debug mailbox: window base address,
// register offsets inside the two-word window, STATUS bit positions and a
// byte-lane masking helper.
// Optional feature macro used by the files importing this package:
//   DBG_MBOX_IRQ_EN - implements irq_en and the registered irq_o.
package dbg_mbox_pkg;

    // First word of the debug window; the wrapper gates wbs_cyc_i to it.
    localparam logic [31:0] WINDOW_BASE = 32'h300F_FFF8;

    // Offsets inside the window. Only bit 2 differs, so that is all we decode.
    localparam logic [2:0] STATUS_OFF = 3'd0;
    localparam logic [2:0] DATA_OFF   = 3'd4;

    // STATUS register bit positions (count sits in the low CNT_W bits).
    localparam int FULL_BIT   = 16;
    localparam int EMPTY_BIT  = 17;
    localparam int OVF_BIT    = 18;
    localparam int MBOX_V_BIT = 19;
    localparam int IRQ_EN_BIT = 24;

    // Keep selected byte lanes, zero the others.
    function automatic logic [31:0] apply_sel(input logic [31:0] d,
                                              input logic [3:0]  sel);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = sel[i] ? d[i*8 +: 8] : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/dbg_mbox_fifo.sv
// dbg_mbox_fifo
// Synchronous circular-buffer FIFO with first-word fall-through head.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (clears storage)
//   push_i, push_data_i push request and word
//   pop_i              pop request (ignored while empty)
//   head_o, valid_o    head word (0 while empty) and non-empty flag
//   full_o, empty_o    occupancy flags
//   count_o            occupancy 0..DEPTH
//   drop_o             push was refused because the FIFO was full
module dbg_mbox_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [31:0]      push_data_i,
    input  logic             pop_i,
    output logic [31:0]      head_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             drop_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign valid_o = ~empty_o;
    assign count_o = count_q;
    assign head_o  = empty_o ? 32'h0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when a real pop happens alongside it.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & ~push_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_debug_mailbox.sv
// wb_debug_mailbox
// Wishbone slave in the user-wrapper debug window (0x300FFFF8/0x300FFFFC).
// Firmware pushes words into a FIFO the bench drains (tb_*), and the bench
// posts a single word into a mailbox that firmware reads.
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbs_*                  Wishbone slave (cyc pre-gated to the window,
//                          adr[2] selects STATUS(0)/DATA(1))
//   tb_valid_o, tb_data_o  FIFO non-empty and head word
//   tb_pop_i               bench pops the head
//   tb_mbox_we_i/data_i    bench writes the mailbox
//   irq_o                  mailbox interrupt
// Optional feature macro: DBG_MBOX_IRQ_EN (irq_en register and irq_o;
// without it irq_o is 0 and STATUS[24] reads 0).
//
// Handshake: a request is cyc & stb & ~ack. Every request is acked by a
// registered one-cycle pulse on the next edge; ack drops on the following
// edge even if stb is held, so each access takes two cycles. All side
// effects happen on the request edge, once per access. wbs_dat_o is
// registered with the request and is 0 whenever ack is low.
module wb_debug_mailbox
    import dbg_mbox_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tb_valid_o,
    output logic [31:0] tb_data_o,
    input  logic        tb_pop_i,
    input  logic        tb_mbox_we_i,
    input  logic [31:0] tb_mbox_data_i,
    output logic        irq_o
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      mbox_q, mbox_d;
    logic             mbox_v_q, mbox_v_d;

    logic             req;
    logic             sel_data;
    logic             wr_data, rd_data, wr_status;
    logic [31:0]      status;
    logic [31:0]      rdata;

    logic             f_full, f_empty, f_drop;
    logic [CNT_W-1:0] f_count;

    // Address bits other than bit 2 are fixed by the wrapper's window gating.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:3], wbs_adr_i[1:0]};

    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign sel_data  = wbs_adr_i[2];   // DATA_OFF has bit 2 set, STATUS_OFF not
    assign wr_data   = req &  wbs_we_i &  sel_data;
    assign rd_data   = req & ~wbs_we_i &  sel_data;
    assign wr_status = req &  wbs_we_i & ~sel_data;

    dbg_mbox_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .push_i      (wr_data),
        .push_data_i (apply_sel(wbs_dat_i, wbs_sel_i)),
        .pop_i       (tb_pop_i),
        .head_o      (tb_data_o),
        .valid_o     (tb_valid_o),
        .full_o      (f_full),
        .empty_o     (f_empty),
        .count_o     (f_count),
        .drop_o      (f_drop)
    );

`ifdef DBG_MBOX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;
`endif

    always_comb begin
        status                 = '0;
        status[CNT_W-1:0]      = f_count;
        status[FULL_BIT]       = f_full;
        status[EMPTY_BIT]      = f_empty;
        status[OVF_BIT]        = ovf_q;
        status[MBOX_V_BIT]     = mbox_v_q;
`ifdef DBG_MBOX_IRQ_EN
        status[IRQ_EN_BIT]     = irq_en_q;
`endif
    end

    assign rdata = sel_data ? mbox_q : status;

    always_comb begin
        ack_d    = req;
        dat_d    = (req & ~wbs_we_i) ? rdata : 32'h0;

        // A clear and a drop cannot coincide: one access per request edge.
        ovf_d    = ovf_q;
        if (wr_status && wbs_sel_i[2] && wbs_dat_i[OVF_BIT]) ovf_d = 1'b0;
        if (f_drop) ovf_d = 1'b1;

        // A bench write in the same cycle as a firmware read wins, so the
        // fresh word is not lost.
        mbox_d   = mbox_q;
        mbox_v_d = mbox_v_q;
        if (tb_mbox_we_i) begin
            mbox_d   = tb_mbox_data_i;
            mbox_v_d = 1'b1;
        end else if (rd_data) begin
            mbox_v_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            ovf_q    <= 1'b0;
            mbox_q   <= '0;
            mbox_v_q <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            ovf_q    <= ovf_d;
            mbox_q   <= mbox_d;
            mbox_v_q <= mbox_v_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

`ifdef DBG_MBOX_IRQ_EN
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_status && wbs_sel_i[3]) irq_en_d = wbs_dat_i[IRQ_EN_BIT];
    end

    // Registered from next-state values so irq_o always equals
    // irq_en & mbox_valid as seen in STATUS.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d & mbox_v_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_debug_mailbox.sv
// tb_wb_debug_mailbox
// Directed steps followed by random traffic, checked against a queue-based
// model of the FIFO plus a few scalar flags for overflow and the mailbox.
module tb_wb_debug_mailbox;

    localparam int DEPTH = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        tb_valid;
    logic [31:0] tb_data;
    logic        tb_pop;
    logic        mb_we;
    logic [31:0] mb_data;
    logic        irq;

    always #5 clk = ~clk;

    wb_debug_mailbox #(.DEPTH(DEPTH)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_cyc_i      (cyc),
        .wbs_stb_i      (stb),
        .wbs_we_i       (we),
        .wbs_sel_i      (sel),
        .wbs_adr_i      (adr),
        .wbs_dat_i      (dat_i),
        .wbs_ack_o      (ack),
        .wbs_dat_o      (dat_o),
        .tb_valid_o     (tb_valid),
        .tb_data_o      (tb_data),
        .tb_pop_i       (tb_pop),
        .tb_mbox_we_i   (mb_we),
        .tb_mbox_data_i (mb_data),
        .irq_o          (irq)
    );

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    logic        m_ovf;
    logic [31:0] m_mbox;
    logic        m_mv;
    logic        m_irq_en;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = d[i*8 +: 8];
        return m;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int n;
        n = exp_q.size();
        s = 32'(n);
        s[16] = (n == DEPTH);
        s[17] = (n == 0);
        s[18] = m_ovf;
        s[19] = m_mv;
`ifdef DBG_MBOX_IRQ_EN
        s[24] = m_irq_en;
`endif
        return s;
    endfunction

    function automatic logic exp_irq();
`ifdef DBG_MBOX_IRQ_EN
        return m_irq_en & m_mv;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_ovf    = 1'b0;
        m_mbox   = 32'h0;
        m_mv     = 1'b0;
        m_irq_en = 1'b0;
    endfunction

    task automatic check_side(input string tag);
        chk({tag, "_valid"}, 32'(tb_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk({tag, "_head"}, tb_data, exp_q[0]);
        chk({tag, "_irq"}, 32'(irq), 32'(exp_irq()));
    endtask

    // ---------------- driver tasks ----------------
    // One Wishbone access, optionally with a bench pop and/or mailbox write
    // landing on the same request edge. stb is held across the ack edge to
    // confirm that ack still drops and no second request is taken.
    task automatic wb_access(input logic we_v, input logic adr2, input logic [3:0] sel_v,
                             input logic [31:0] d, input logic do_pop, input logic do_mbw,
                             input logic [31:0] mbw, output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic        full_before, pop_ok;
        exp_rd = adr2 ? m_mbox : model_status();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = we_v; sel = sel_v; dat_i = d;
        adr = 32'h300F_FFF8 | (adr2 ? 32'h4 : 32'h0);
        tb_pop = do_pop; mb_we = do_mbw; mb_data = mbw;
        #1 chk("ack_early", 32'(ack), 32'h0);
        @(posedge clk); #1;
        chk("ack_lat", 32'(ack), 32'h1);
        rdata = dat_o;
        if (!we_v) chk(adr2 ? "rd_data" : "rd_status", dat_o, exp_rd);
        // model update for the request edge
        full_before = (exp_q.size() == DEPTH);
        pop_ok      = do_pop && (exp_q.size() != 0);
        if (pop_ok) void'(exp_q.pop_front());
        if (we_v && adr2) begin
            if (!full_before || pop_ok) exp_q.push_back(masked(d, sel_v));
            else m_ovf = 1'b1;
        end
        if (we_v && !adr2) begin
            if (sel_v[2] && d[18]) m_ovf = 1'b0;
`ifdef DBG_MBOX_IRQ_EN
            if (sel_v[3]) m_irq_en = d[24];
`endif
        end
        if (!we_v && adr2) m_mv = 1'b0;
        if (do_mbw) begin
            m_mbox = mbw;
            m_mv   = 1'b1;
        end
        check_side("acc");
        @(negedge clk);
        tb_pop = 1'b0; mb_we = 1'b0;
        @(posedge clk); #1;
        chk("ack_drop", 32'(ack), 32'h0);
        chk("dat_idle", dat_o, 32'h0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic adr2, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        wb_access(1'b1, adr2, s, d, 1'b0, 1'b0, 32'h0, r);
    endtask

    task automatic wb_read(input logic adr2, output logic [31:0] r);
        wb_access(1'b0, adr2, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, r);
    endtask

    task automatic bench_pop();
        @(negedge clk);
        check_side("pre_pop");
        tb_pop = 1'b1;
        @(posedge clk); #1;
        tb_pop = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check_side("pop");
    endtask

    task automatic bench_mbox(input logic [31:0] d);
        @(negedge clk);
        mb_we = 1'b1; mb_data = d;
        @(posedge clk); #1;
        mb_we = 1'b0;
        m_mbox = d;
        m_mv   = 1'b1;
        check_side("mbw");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        logic [31:0] exp_after_clear;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat_i = 32'h0; tb_pop = 1'b0; mb_we = 1'b0; mb_data = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_valid", 32'(tb_valid), 32'h0);
        chk("rst_tbdata", tb_data, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // STATUS after reset: only empty set
        wb_read(1'b0, r);
        chk("status_rst", r, 32'h0002_0000);

        // Three pushes drained by the bench in order
        wb_write(1'b1, 4'hF, 32'h11);
        wb_write(1'b1, 4'hF, 32'h22);
        wb_write(1'b1, 4'hF, 32'h33);
        chk("head_11", tb_data, 32'h11);
        bench_pop();
        chk("head_22", tb_data, 32'h22);
        bench_pop();
        chk("head_33", tb_data, 32'h33);
        bench_pop();
        chk("valid_fall", 32'(tb_valid), 32'h0);

        // Fill, overflow on the ninth word, then clear overflow
        for (int i = 0; i < DEPTH; i++) wb_write(1'b1, 4'hF, $urandom);
        wb_write(1'b1, 4'hF, 32'hDEAD);
        wb_read(1'b0, r);
        chk("status_ovf", r, 32'h0005_0008);
        wb_write(1'b0, 4'hF, 32'h0004_0000);
        exp_after_clear = 32'h0001_0008;
        wb_read(1'b0, r);
        chk("status_ovf_clr", r, exp_after_clear);

        // Full FIFO: push and pop on the same edge, no overflow
        wb_access(1'b1, 1'b1, 4'hF, 32'h5A5A_0001, 1'b1, 1'b0, 32'h0, r);
        wb_read(1'b0, r);
        chk("status_full_pp", r, 32'h0001_0008);
        while (exp_q.size() != 0) bench_pop();

        // Byte-lane masking
        wb_write(1'b1, 4'b0101, 32'hAABB_CCDD);
        chk("head_masked", tb_data, 32'h00BB_00DD);
        bench_pop();

        // Mailbox with interrupt enabled (irq_en ignored when not built in)
        wb_write(1'b0, 4'b1000, 32'h0100_0000);
        bench_mbox(32'h0000_CAFE);
        wb_read(1'b1, r);
        chk("mbox_cafe", r, 32'h0000_CAFE);
        wb_read(1'b0, r);
        chk("mbox_v_clr", 32'(r[19]), 32'h0);

        // Bench write on the same edge as a firmware DATA read keeps mbox_valid
        bench_mbox(32'h1234_5678);
        wb_access(1'b0, 1'b1, 4'hF, 32'h0, 1'b0, 1'b1, 32'h8765_4321, r);
        chk("mbox_race_old", r, 32'h1234_5678);
        wb_read(1'b0, r);
        chk("mbox_race_v", 32'(r[19]), 32'h1);
        wb_read(1'b1, r);
        chk("mbox_race_new", r, 32'h8765_4321);

        // Random traffic against the model
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 5))
                0, 1: wb_write(1'b1, 4'($urandom_range(0, 15)), $urandom);
                2:    wb_read(1'b0, r);
                3:    wb_read(1'b1, r);
                4:    bench_pop();
                default: begin
                    if ($urandom_range(0, 1) == 0) bench_mbox($urandom);
                    else wb_write(1'b0, 4'($urandom_range(0, 15)), $urandom);
                end
            endcase
        end

        // Reset while an ack is pending: ack dropped, FIFO flushed
        wb_write(1'b1, 4'hF, 32'h0BAD_F00D);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat_i = 32'h7777_7777;
        adr = 32'h300F_FFFC;
        @(posedge clk); #1;
        chk("mid_ack", 32'(ack), 32'h1);
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_valid", 32'(tb_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wb_read(1'b0, r);
        chk("mid_rst_status", r, 32'h0002_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_debug_mailbox.md
Name: wb_debug_mailbox

Overview:
- Wishbone slave behind the user-wrapper debug window: the last two words of user address space, 0x300FFFF8 and 0x300FFFFC.
- Gives firmware and the cocotb bench a two-way mailbox:
  - Firmware-to-bench: a DEPTH-entry FIFO that firmware writes and the bench drains.
  - Bench-to-firmware: a single-word mailbox that the bench writes and firmware reads.
- The wrapper gates wbs_cyc_i so it is only asserted for the debug window. The block decodes wbs_adr_i[2] only.

Parameters:
- DEPTH, 8, FIFO entries. Power of two, 2..128.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width. Derived; never overridden.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_cyc_i  in  1  cycle, pre-gated to the debug window.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i  in  32  address; only bit 2 is used.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- tb_valid_o  out  1  FIFO non-empty.
- tb_data_o  out  32  FIFO head (first-word fall-through).
- tb_pop_i  in  1  bench pops the head.
- tb_mbox_we_i  in  1  bench writes the mailbox.
- tb_mbox_data_i  in  32  bench mailbox data.
- irq_o  out  1  mailbox interrupt (see Optional Feature).

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_i is synchronous and active-high.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, tb_valid_o=0, tb_data_o=0 (FIFO storage cleared), irq_o=0. Count, pointers, overflow, mbox_valid and irq_en all 0.
- Reset mid-transaction: a pending ack is dropped and the FIFO is flushed. The master must retry.
- Handshake:
  - Request = cyc & stb & ~ack.
  - wbs_ack_o is a registered single-cycle pulse, asserted 1 cycle after the request.
  - Ack always drops the cycle after it is asserted, even if stb is held. Back-to-back accesses therefore take 2 cycles each.
  - Side effects (push, pop, clear) occur on the request edge, exactly once per access.
- Read data: wbs_dat_o is registered on the request and valid with ack. It is 0 when ack is low.
- Address map: adr[2]=0 selects STATUS; adr[2]=1 selects DATA.
- STATUS read:
  - [CNT_W-1:0] = count.
  - [16] = full.
  - [17] = empty.
  - [18] = overflow (sticky).
  - [19] = mbox_valid.
  - [24] = irq_en.
  - All other bits 0.
- STATUS write:
  - If sel[2] and dat[18]=1, overflow clears (write-1-to-clear).
  - If sel[3], irq_en takes dat[24].
  - Other bits are ignored.
- DATA write:
  - Pushes the sel-masked word; unselected bytes are 0.
  - If the FIFO is full, the word is dropped, overflow is set, and the access is still acked.
- DATA read:
  - Returns the mailbox word and clears mbox_valid. Reads return the stale word when mbox_valid=0.
  - If a tb_mbox_we_i write lands in the same cycle, the new word is stored and mbox_valid stays 1.
- FIFO:
  - Circular buffer with wrap-around pointers of log2(DEPTH) bits; count ranges 0..DEPTH.
  - tb_pop_i while empty is ignored.
  - Push and pop in the same cycle:
    - Not full, not empty: both occur; count is unchanged.
    - Full: both occur; the push is accepted and overflow is not set.
    - Empty: the push occurs and the pop is ignored.
- Mailbox: tb_mbox_we_i writes the mailbox and sets mbox_valid. A bench overwrite while mbox_valid=1 is silently allowed.

Optional Feature:
- Macro: DBG_MBOX_IRQ_EN.
- Defined: irq_o is registered and equals irq_en & mbox_valid. It rises 1 cycle after the bench write and falls 1 cycle after the firmware DATA read. It feeds user_irq[0].
- Undefined: irq_o is tied to 0, irq_en is not implemented, and STATUS[24] reads 0.

Decomposition:
- Package dbg_mbox_pkg holds:
  - Offsets: STATUS_OFF=0, DATA_OFF=4.
  - STATUS bit indices: FULL=16, EMPTY=17, OVF=18, MBOX_V=19, IRQ_EN=24.
  - Window base: 0x300FFFF8.
- Sub-module dbg_mbox_fifo: sync FIFO with push/pop/full/empty/count and FWFT head. The top module holds the Wishbone decode, mailbox and irq logic.

Test Plan:
- Reset, then read STATUS → 0x0002_0000 (empty=1). Ack arrives exactly 1 cycle after stb and lasts 1 cycle.
- Write DATA 0x11,0x22,0x33 with sel=F, then assert tb_pop_i three times → tb_data_o=0x11,0x22,0x33; tb_valid_o falls after the third pop.
- Fill 8 words, write a 9th word 0xDEAD → dropped and acked; STATUS=0x0005_0008. Write STATUS with 0x0004_0000 → overflow cleared.
- Write DATA 0xAABBCCDD with sel=4'b0101 → head=0x00BB00DD.
- Bench writes mailbox 0xCAFE, firmware reads DATA → 0xCAFE and mbox_valid=0. With DBG_MBOX_IRQ_EN and irq_en=1, irq_o high 1 cycle after the bench write and low 1 cycle after the read.
- With the FIFO full, push and pop in the same cycle → count stays 8 and overflow stays 0. Assert reset during a pending ack → ack=0 and count=0.
